control_sequencer: RTL

Microcode control unit that consumes the 3-bit step index from the stepper, drives the CPU control word for the current step, and returns an end-of-instruction clear to the stepper. It latches the opcode during fetch, decodes fetch (steps 0–1) and execute (steps 2–4), and handles halt. It also checks the incoming step index against its own shadow count and flags loss of sync.

---
 rtl/risc8_pkg.sv | 52 +++++
 rtl/control_sequencer_if.sv | 27 ++
 rtl/microcode_rom.sv | 70 +++++++
 rtl/control_sequencer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/risc8_pkg.sv
// Shared definitions for the 8-bit microcoded CPU: control-word bit positions,
// opcode encodings and the sequencer state type.
package risc8_pkg;

    // Control-word bit positions (bit 15 is the MSB of ctrl).
    localparam int unsigned CB_HLT = 15;
    localparam int unsigned CB_MI  = 14;
    localparam int unsigned CB_RI  = 13;
    localparam int unsigned CB_RO  = 12;
    localparam int unsigned CB_IO  = 11;
    localparam int unsigned CB_II  = 10;
    localparam int unsigned CB_AI  = 9;
    localparam int unsigned CB_AO  = 8;
    localparam int unsigned CB_EO  = 7;
    localparam int unsigned CB_SU  = 6;
    localparam int unsigned CB_BI  = 5;
    localparam int unsigned CB_OI  = 4;
    localparam int unsigned CB_CE  = 3;
    localparam int unsigned CB_CO  = 2;
    localparam int unsigned CB_J   = 1;
    localparam int unsigned CB_FI  = 0;

    typedef logic [15:0] ctrl_t;
    typedef logic [3:0]  opcode_t;

    // Opcode encodings (bus[7:4] during fetch step 1). 9..D are illegal.
    localparam opcode_t OP_NOP = 4'h0;
    localparam opcode_t OP_LDA = 4'h1;
    localparam opcode_t OP_ADD = 4'h2;
    localparam opcode_t OP_SUB = 4'h3;
    localparam opcode_t OP_STA = 4'h4;
    localparam opcode_t OP_LDI = 4'h5;
    localparam opcode_t OP_JMP = 4'h6;
    localparam opcode_t OP_JC  = 4'h7;
    localparam opcode_t OP_JZ  = 4'h8;
    localparam opcode_t OP_OUT = 4'hE;
    localparam opcode_t OP_HLT = 4'hF;

    // Sequencer states: normal stepping, one idle cycle while the stepper
    // clears, and the terminal halt state.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BUBBLE  = 2'd1,
        ST_HALTED  = 2'd2
    } seq_state_t;

    // One-hot control word with only bit idx set.
    function automatic ctrl_t cbit(input int unsigned idx);
        cbit = ctrl_t'(16'd1) << idx;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Signal bundle between the stepper/CPU datapath (master) and the
// control sequencer (slave).
interface control_sequencer_if
    import risc8_pkg::*;
();
    logic [2:0] step;
    logic [7:0] bus;
    logic       flag_c;
    logic       flag_z;
    ctrl_t      ctrl;
    logic       step_rst;
    opcode_t    opcode;
    logic       halted;
    logic       sync_err;

    // Datapath side: supplies step, bus and flags, consumes the control word.
    modport master (
        output step, bus, flag_c, flag_z,
        input  ctrl, step_rst, opcode, halted, sync_err
    );

    // Sequencer side.
    modport slave (
        input  step, bus, flag_c, flag_z,
        output ctrl, step_rst, opcode, halted, sync_err
    );
endinterface

// File: rtl/microcode_rom.sv
// Combinational microcode store: maps (opcode, step, flags) to the control
// word and reports whether this step is the last one of the instruction.
module microcode_rom
    import risc8_pkg::*;
(
    input  opcode_t    opcode,
    input  logic [2:0] step,
    input  logic       flag_c,
    input  logic       flag_z,
    output ctrl_t      ctrl,
    output logic       last_step
);

    logic [2:0] last_idx;

    // Instruction length lookup: index of the final step per opcode.
    always_comb begin
        last_idx = 3'd1;
        case (opcode)
            OP_LDA, OP_STA:                                 last_idx = 3'd3;
            OP_ADD, OP_SUB:                                 last_idx = 3'd4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:   last_idx = 3'd2;
            default:                                        last_idx = 3'd1;
        endcase
    end

    // Control word: shared fetch for steps 0-1, opcode-specific execute after.
    always_comb begin
        ctrl = '0;
        case (step)
            3'd0: ctrl = cbit(CB_CO) | cbit(CB_MI);
            3'd1: ctrl = cbit(CB_RO) | cbit(CB_II) | cbit(CB_CE);
            3'd2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA:
                        ctrl = cbit(CB_IO) | cbit(CB_MI);
                    OP_LDI: ctrl = cbit(CB_IO) | cbit(CB_AI);
                    OP_JMP: ctrl = cbit(CB_IO) | cbit(CB_J);
                    OP_JC:  ctrl = flag_c ? (cbit(CB_IO) | cbit(CB_J)) : '0;
                    OP_JZ:  ctrl = flag_z ? (cbit(CB_IO) | cbit(CB_J)) : '0;
                    OP_OUT: ctrl = cbit(CB_AO) | cbit(CB_OI);
                    OP_HLT: ctrl = cbit(CB_HLT);
                    default: ctrl = '0;
                endcase
            end
            3'd3: begin
                case (opcode)
                    OP_LDA:         ctrl = cbit(CB_RO) | cbit(CB_AI);
                    OP_ADD, OP_SUB: ctrl = cbit(CB_RO) | cbit(CB_BI);
                    OP_STA:         ctrl = cbit(CB_AO) | cbit(CB_RI);
                    default:        ctrl = '0;
                endcase
            end
            3'd4: begin
                case (opcode)
                    OP_ADD:  ctrl = cbit(CB_EO) | cbit(CB_AI) | cbit(CB_FI);
                    OP_SUB:  ctrl = cbit(CB_EO) | cbit(CB_AI) | cbit(CB_FI) | cbit(CB_SU);
                    default: ctrl = '0;
                endcase
            end
            default: ctrl = '0;
        endcase
    end

    // Steps past the end of the instruction never match and emit no control.
    always_comb begin
        last_step = (step == last_idx);
    end

endmodule

// File: rtl/control_sequencer.sv
// Microcode control unit: decodes the stepper's step index into the CPU
// control word, latches the opcode during fetch, ends each instruction with a
// one-cycle bubble that clears the stepper, handles halt, and watches for the
// stepper drifting away from a shadow step count.
module control_sequencer
    import risc8_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    control_sequencer_if.slave cs
);

    seq_state_t state_q, state_d;
    opcode_t    opcode_q, opcode_d;
    logic [2:0] exp_q, exp_d;
    logic       step_rst_q, step_rst_d;
    logic       halted_q, halted_d;
    logic       sync_err_q, sync_err_d;

    opcode_t    rom_op;
    ctrl_t      rom_ctrl;
    logic       rom_last;

    // The operand nibble is carried on the bus but not used by the sequencer.
    logic       unused_bus_lo;

    // During step 1 the opcode register still holds the previous instruction,
    // so the length check must look at the opcode arriving on the bus.
    always_comb begin
        rom_op = (cs.step == 3'd1) ? opcode_t'(cs.bus[7:4]) : opcode_q;
    end

    microcode_rom u_rom (
        .opcode    (rom_op),
        .step      (cs.step),
        .flag_c    (cs.flag_c),
        .flag_z    (cs.flag_z),
        .ctrl      (rom_ctrl),
        .last_step (rom_last)
    );

    // Control word is zero-latency from step, but silenced outside RUN and
    // while reset is held.
    always_comb begin
        cs.ctrl = (reset && (state_q == ST_RUN)) ? rom_ctrl : '0;
    end

    // Next-state logic for the sequencer, opcode latch, shadow counter and
    // sticky sync-error flag.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        exp_d      = exp_q;
        step_rst_d = step_rst_q;
        halted_d   = halted_q;
        sync_err_d = sync_err_q;
        case (state_q)
            ST_RUN: begin
                exp_d = exp_q + 3'd1;
                if (cs.step != exp_q) begin
                    sync_err_d = 1'b1;
                end
                if (cs.step == 3'd1) begin
                    opcode_d = opcode_t'(cs.bus[7:4]);
                end
                if (rom_last) begin
                    step_rst_d = 1'b1;
                    if ((cs.step == 3'd2) && (opcode_q == OP_HLT)) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        state_d = ST_BUBBLE;
                    end
                end
            end
            ST_BUBBLE: begin
                state_d    = ST_RUN;
                step_rst_d = 1'b0;
                exp_d      = 3'd0;
            end
            ST_HALTED: begin
                step_rst_d = 1'b1;
                halted_d   = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                step_rst_d = 1'b0;
                exp_d      = 3'd0;
            end
        endcase
    end

    // State and registered outputs; reset may land mid-instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            opcode_q   <= '0;
            exp_q      <= '0;
            step_rst_q <= 1'b0;
            halted_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            exp_q      <= exp_d;
            step_rst_q <= step_rst_d;
            halted_q   <= halted_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Drive the registered outputs onto the interface.
    always_comb begin
        cs.step_rst   = step_rst_q;
        cs.opcode     = opcode_q;
        cs.halted     = halted_q;
        cs.sync_err   = sync_err_q;
        unused_bus_lo = ^cs.bus[3:0];
    end

endmodule
